// File: rtl/fp_div_pkg.sv
// rtl/fp_div_pkg.sv - shared types and constants for the single-precision divider
package fp_div_pkg;
    localparam int EXP_W    = 8;
    localparam int MAN_W    = 23;
    localparam int BIAS     = 127;
    localparam int ITER_DEF = 26;

    localparam logic [31:0]      QNAN    = 32'h7FC00000;
    localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        DIV,
        NORM,
        DONE
    } state_e;
endpackage

// File: rtl/fp_div_mant.sv
// rtl/fp_div_mant.sv - restoring mantissa divider, one quotient bit per step
module fp_div_mant
    import fp_div_pkg::*;
#(
    parameter int ITER = ITER_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             step_i,
    input  logic [MAN_W-1:0] ma_i,
    input  logic [MAN_W-1:0] mb_i,
    output logic [ITER-1:0]  qr_o,
    output logic             rem_nz_o,
    output logic             last_o
);
    logic [MAN_W+1:0] r_q, r_d;
    logic [MAN_W:0]   d_q;
    logic [ITER-1:0]  qr_q, qr_d;
    logic [4:0]       cnt_q;
    logic             ge;
    logic [MAN_W+1:0] diff;

    // R < 2D always holds, so both shifted forms fit in 25 bits
    assign ge   = r_q >= {1'b0, d_q};
    assign diff = r_q - {1'b0, d_q};

    always_comb begin
        r_d  = ge ? {diff[MAN_W:0], 1'b0} : {r_q[MAN_W:0], 1'b0};
        qr_d = {qr_q[ITER-2:0], ge};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q   <= '0;
            d_q   <= '0;
            qr_q  <= '0;
            cnt_q <= '0;
        end else if (load_i) begin
            r_q   <= {2'b01, ma_i};
            d_q   <= {1'b1, mb_i};
            qr_q  <= '0;
            cnt_q <= 5'(ITER - 1);
        end else if (step_i) begin
            r_q   <= r_d;
            qr_q  <= qr_d;
            cnt_q <= cnt_q - 5'd1;
        end
    end

    assign qr_o     = qr_q;
    assign rem_nz_o = |r_q;
    assign last_o   = cnt_q == 5'd0;
endmodule

// File: rtl/fp_divider.sv
// rtl/fp_divider.sv - sequential IEEE-754 single divider; FP_DIV_ROUND_EN selects RNE rounding
module fp_divider
    import fp_div_pkg::*;
#(
    parameter int ITER = ITER_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] q
);
    state_e state_q, state_d;
    logic               sign_q, spec_q;
    logic [31:0]        spec_res_q, q_q, q_d;
    logic signed [9:0]  ex_q;

    logic [EXP_W-1:0]   ea, eb;
    logic [MAN_W-1:0]   ma, mb;
    logic               a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, s_in, spec_in, accept;
    logic [31:0]        spec_res_in, norm_res;
    logic signed [9:0]  ex_in, e_n, e_f;
    logic [ITER-1:0]    qr;
    logic               rem_nz, last;
    logic [MAN_W-1:0]   mant, mant_r;
    logic               guard, sticky;

    assign ea     = a[30:23];
    assign eb     = b[30:23];
    assign ma     = a[22:0];
    assign mb     = b[22:0];
    assign a_zero = ea == '0;
    assign b_zero = eb == '0;
    assign a_inf  = (ea == EXP_MAX) && (ma == '0);
    assign b_inf  = (eb == EXP_MAX) && (mb == '0);
    assign a_nan  = (ea == EXP_MAX) && (ma != '0);
    assign b_nan  = (eb == EXP_MAX) && (mb != '0);
    assign s_in   = a[31] ^ b[31];
    assign ex_in  = 10'({2'b00, ea}) - 10'({2'b00, eb}) + 10'(BIAS);
    assign accept = (state_q == IDLE) && start;

    always_comb begin
        spec_in     = 1'b1;
        spec_res_in = QNAN;
        if (a_nan || b_nan)                            spec_res_in = QNAN;
        else if ((a_zero && b_zero) || (a_inf && b_inf)) spec_res_in = QNAN;
        else if (a_inf || b_zero)                      spec_res_in = {s_in, EXP_MAX, 23'h0};
        else if (a_zero || b_inf)                      spec_res_in = {s_in, 31'h0};
        else begin
            spec_in     = 1'b0;
            spec_res_in = 32'h0;
        end
    end

    fp_div_mant #(.ITER(ITER)) u_mant (
        .clk      (clk),
        .rst      (rst),
        .load_i   (accept),
        .step_i   (state_q == DIV),
        .ma_i     (ma),
        .mb_i     (mb),
        .qr_o     (qr),
        .rem_nz_o (rem_nz),
        .last_o   (last)
    );

    always_comb begin
        if (qr[25]) begin
            mant   = qr[24:2];
            guard  = qr[1];
            sticky = qr[0] | rem_nz;
            e_n    = ex_q;
        end else begin
            mant   = qr[23:1];
            guard  = qr[0];
            sticky = rem_nz;
            e_n    = ex_q - 10'sd1;
        end
    end

`ifdef FP_DIV_ROUND_EN
    logic       inc, carry;
    assign inc             = guard & (sticky | mant[0]);
    assign {carry, mant_r} = {1'b0, mant} + {23'h0, inc};
    assign e_f             = e_n + {9'h0, carry};
`else
    logic round_unused;
    assign round_unused = guard | sticky;
    assign mant_r       = mant;
    assign e_f          = e_n;
`endif

    always_comb begin
        if (e_f >= 10'sd255)    norm_res = {sign_q, EXP_MAX, 23'h0};
        else if (e_f <= 10'sd0) norm_res = {sign_q, 31'h0};
        else                    norm_res = {sign_q, e_f[7:0], mant_r};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            q_q        <= 32'h0;
            sign_q     <= 1'b0;
            spec_q     <= 1'b0;
            spec_res_q <= 32'h0;
            ex_q       <= '0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            if (accept) begin
                sign_q     <= s_in;
                spec_q     <= spec_in;
                spec_res_q <= spec_res_in;
                ex_q       <= ex_in;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = CHECK;
            CHECK:   state_d = spec_q ? DONE : DIV;
            DIV:     if (last) state_d = NORM;
            NORM:    state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        q_d  = q_q;
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            CHECK: begin
                busy = 1'b1;
                if (spec_q) q_d = spec_res_q;
            end
            DIV:   busy = 1'b1;
            NORM: begin
                busy = 1'b1;
                q_d  = norm_res;
            end
            DONE:  done = 1'b1;
            default: ;
        endcase
    end

    assign q = q_q;
endmodule
